// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue
//   Fetch stage in front of instruction decode. Walks the PC sequentially and
//   issues one instruction-memory read at a time. Returned words are buffered
//   in a DEPTH-entry FIFO, and decode sees the head entry as {instr, pc}.
//   A taken control transfer from decode (jump && jaccept) flushes the FIFO
//   and restarts fetch at the word-aligned jaddr. Any read still in flight
//   when the redirect happens is discarded when it returns.
//
// Ports
//   clk, rst        rising-edge clock; asynchronous active-high reset
//   imem_req/addr   out: one-cycle read strobe and word address
//   imem_valid/rdata in: read return, at least one cycle after its request
//   jump, jaccept   in: decode reports a control transfer / that it is taken
//   jaddr           in: redirect target (bits [1:0] are ignored)
//   id_ready        in: decode consumes the head entry this cycle
//   fetch_valid     out: head entry valid
//   fetch_instr_pc  out: {instr[31:0], pc[31:0]} of the head entry, 0 when empty
//
// Handshakes
//   Decode side: an entry moves when fetch_valid && id_ready in a cycle with
//   no redirect. fetch_instr_pc is held stable while fetch_valid && !id_ready.
//   Memory side: imem_req is a one-cycle strobe with no back-pressure. At most
//   one read is outstanding. A request is made only when a FIFO slot is already
//   reserved for its data, so imem_valid never needs a ready.

module instr_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  input  logic        jump,
  input  logic        jaccept,
  input  logic [31:0] jaddr,
  input  logic        id_ready,
  output logic        fetch_valid,
  output logic [63:0] fetch_instr_pc
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [31:0]   pc_q, pc_d;
  logic [31:0]   req_pc_q, req_pc_d;
  logic          inflight_q, inflight_d;
  logic          drop_q, drop_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [63:0]   fifo_q [DEPTH];
  logic [63:0]   fifo_d [DEPTH];

  logic          redirect;
  logic          resp;
  logic          resp_kept;
  logic [CW-1:0] fill;
  logic          push;
  logic          pop;

  assign fetch_valid    = (count_q != '0);
  assign fetch_instr_pc = fetch_valid ? fifo_q[rd_ptr_q] : 64'd0;
  assign imem_addr      = pc_q;

  always_comb begin
    redirect  = jump & jaccept;
    resp      = imem_valid & inflight_q;
    resp_kept = resp & ~drop_q;
    // Occupancy once a returning, non-dropped word lands. Requesting only
    // while this is below DEPTH reserves the slot for the new read.
    fill      = count_q + CW'(resp_kept);
    // rst is included so the strobe is low for as long as reset is held,
    // not only once the registers have been cleared.
    imem_req  = ~rst & ~redirect & (~inflight_q | imem_valid) & (fill < DEPTH_C);
    push      = resp_kept & ~redirect;
    pop       = fetch_valid & id_ready & ~redirect;

    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = inflight_q;
    drop_d     = drop_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    fifo_d     = fifo_q;

    if (redirect) begin
      pc_d     = {jaddr[31:2], 2'b00};
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      if (inflight_q) begin
        if (imem_valid) begin
          // The word returns in the redirect cycle itself and is thrown away.
          inflight_d = 1'b0;
          drop_d     = 1'b0;
        end else begin
          // The word is still outstanding. Mark it so it is discarded on return.
          drop_d = 1'b1;
        end
      end
    end else begin
      if (imem_req) begin
        pc_d       = pc_q + 32'd4;
        req_pc_d   = pc_q;
        inflight_d = 1'b1;
      end else if (resp) begin
        inflight_d = 1'b0;
      end
      if (resp) begin
        drop_d = 1'b0;
      end
      if (push) begin
        fifo_d[wr_ptr_q] = {imem_rdata, req_pc_q};
        wr_ptr_d         = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      req_pc_q   <= RESET_PC;
      inflight_q <= 1'b0;
      drop_q     <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      fifo_q     <= fifo_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb_instr_fetch_queue
//   Drives instr_fetch_queue (DEPTH=4, RESET_PC=0x100) with a memory responder
//   whose latency is programmable. The expected model is the program-order
//   stream of fetches. Every issued read adds {mem_word(addr), addr} to
//   exp_q. A pop removes the front entry. A redirect or reset clears exp_q,
//   and the next read address is the aligned target. When fetch_valid is
//   high, the head must equal exp_q[0]. Outstanding work (exp_q size) must
//   never exceed DEPTH.

module tb_instr_fetch_queue;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h100;

  typedef struct {
    int unsigned due;
    logic [31:0] addr;
  } mem_req_t;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic        jump;
  logic        jaccept;
  logic [31:0] jaddr;
  logic        id_ready;
  logic        fetch_valid;
  logic [63:0] fetch_instr_pc;

  instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_valid     (imem_valid),
    .imem_rdata     (imem_rdata),
    .jump           (jump),
    .jaccept        (jaccept),
    .jaddr          (jaddr),
    .id_ready       (id_ready),
    .fetch_valid    (fetch_valid),
    .fetch_instr_pc (fetch_instr_pc)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int unsigned vectors = 0;
  int unsigned errors  = 0;
  int unsigned cyc     = 0;
  int unsigned lat_min = 1;
  int unsigned lat_max = 1;
  logic [31:0] exp_req_addr = RESET_PC;
  logic        expect_empty = 1'b0;
  logic [63:0] exp_q[$];
  mem_req_t    pending[$];
  logic [31:0] req_log[$];
  int unsigned req_cyc[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_1234;
  endfunction

  // One clock cycle. At the negedge, check the outputs against the model and
  // capture any read request. Just after the next posedge, drive a memory
  // response if one is due.
  task automatic tick();
    logic redir;
    @(negedge clk);
    if (rst) begin
      vectors++;
      if (imem_req !== 1'b0 || fetch_valid !== 1'b0 || fetch_instr_pc !== 64'd0) begin
        errors++;
        $display("FAIL reset_outputs: req=%b valid=%b data=%h, required 0 0 0",
                 imem_req, fetch_valid, fetch_instr_pc);
      end
      exp_q.delete();
      exp_req_addr = RESET_PC;
      expect_empty = 1'b0;
    end else begin
      redir = jump & jaccept;
      vectors++;
      if (!fetch_valid) begin
        if (fetch_instr_pc !== 64'd0) begin
          errors++;
          $display("FAIL empty_data: got %h, required 0", fetch_instr_pc);
        end
      end else if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL head_unexpected: got valid head %h, required empty", fetch_instr_pc);
      end else if (fetch_instr_pc !== exp_q[0]) begin
        errors++;
        $display("FAIL head_entry: got %h, required %h", fetch_instr_pc, exp_q[0]);
      end
      if (expect_empty) begin
        vectors++;
        if (fetch_valid !== 1'b0) begin
          errors++;
          $display("FAIL flush_after_redirect: fetch_valid=%b, required 0", fetch_valid);
        end
      end
      expect_empty = 1'b0;
      if (redir) begin
        vectors++;
        if (imem_req !== 1'b0) begin
          errors++;
          $display("FAIL req_during_redirect: imem_req=%b, required 0", imem_req);
        end
        exp_q.delete();
        exp_req_addr = {jaddr[31:2], 2'b00};
        expect_empty = 1'b1;
      end else begin
        if (fetch_valid && id_ready && exp_q.size() > 0) void'(exp_q.pop_front());
        if (imem_req) begin
          vectors++;
          if (imem_addr !== exp_req_addr) begin
            errors++;
            $display("FAIL req_addr: got %h, required %h", imem_addr, exp_req_addr);
          end
          exp_q.push_back({mem_word(imem_addr), imem_addr});
          req_log.push_back(imem_addr);
          req_cyc.push_back(cyc);
          pending.push_back('{cyc + $urandom_range(lat_max, lat_min), imem_addr});
          exp_req_addr = exp_req_addr + 32'd4;
        end
        vectors++;
        if (exp_q.size() > DEPTH) begin
          errors++;
          $display("FAIL occupancy: got %0d outstanding, required <= %0d", exp_q.size(), DEPTH);
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    imem_valid = 1'b0;
    imem_rdata = 32'h0;
    if (pending.size() > 0 && pending[0].due <= cyc) begin
      imem_valid = 1'b1;
      imem_rdata = mem_word(pending[0].addr);
      void'(pending.pop_front());
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    jump = 1'b0; jaccept = 1'b0; jaddr = 32'h0; id_ready = 1'b1;
    lat_min = 1; lat_max = 1;
    pending.delete();
    tick();
    tick();
    rst = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #2;
    vectors++;
    if (imem_req !== 1'b0 || fetch_valid !== 1'b0 || fetch_instr_pc !== 64'd0) begin
      errors++;
      $display("FAIL reset_initial: req=%b valid=%b data=%h, required 0 0 0",
               imem_req, fetch_valid, fetch_instr_pc);
    end
    do_reset();
  endtask

  task automatic test_sequential();
    do_reset();
    req_log.delete(); req_cyc.delete();
    #2;
    vectors++;
    if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
      errors++;
      $display("FAIL first_req: req=%b addr=%h, required 1 %h", imem_req, imem_addr, RESET_PC);
    end
    tick();
    #2;
    vectors++;
    if (fetch_valid !== 1'b0) begin
      errors++;
      $display("FAIL no_early_valid: fetch_valid=%b, required 0", fetch_valid);
    end
    tick();
    #2;
    vectors++;
    if (fetch_valid !== 1'b1 || fetch_instr_pc[31:0] !== 32'h100) begin
      errors++;
      $display("FAIL first_entry_pc: valid=%b pc=%h, required 1 00000100",
               fetch_valid, fetch_instr_pc[31:0]);
    end
    repeat (6) tick();
    vectors++;
    if (req_log.size() < 3 || req_log[0] !== 32'h100 || req_log[1] !== 32'h104 ||
        req_log[2] !== 32'h108 || req_cyc[2] != req_cyc[0] + 2) begin
      errors++;
      $display("FAIL seq_addrs: got %0d requests, first three not 100/104/108 on consecutive cycles",
               req_log.size());
    end
  endtask

  task automatic test_full();
    do_reset();
    id_ready = 1'b0;
    req_log.delete();
    repeat (10) tick();
    #2;
    vectors++;
    if (req_log.size() != 4) begin
      errors++;
      $display("FAIL full_req_count: got %0d, required 4", req_log.size());
    end
    vectors++;
    if (imem_req !== 1'b0) begin
      errors++;
      $display("FAIL full_no_req: imem_req=%b, required 0", imem_req);
    end
    vectors++;
    if (fetch_instr_pc !== {mem_word(32'h100), 32'h100}) begin
      errors++;
      $display("FAIL full_head: got %h, required %h", fetch_instr_pc, {mem_word(32'h100), 32'h100});
    end
    id_ready = 1'b1;
    repeat (8) tick();
  endtask

  task automatic test_redirect_drop();
    do_reset();
    req_log.delete();
    repeat (3) tick();
    lat_min = 3; lat_max = 3;
    tick();
    vectors++;
    if (req_log.size() == 0 || req_log[req_log.size()-1] !== 32'h10C) begin
      errors++;
      $display("FAIL inflight_addr: last request not 0000010c (%0d logged)", req_log.size());
    end
    lat_min = 1; lat_max = 1;
    jump = 1'b1; jaccept = 1'b1; jaddr = 32'h2003;
    tick();
    jump = 1'b0; jaccept = 1'b0;
    #2;
    vectors++;
    if (imem_req !== 1'b0 || fetch_valid !== 1'b0) begin
      errors++;
      $display("FAIL drop_wait: req=%b valid=%b, required 0 0", imem_req, fetch_valid);
    end
    tick();
    #2;
    vectors++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h2000) begin
      errors++;
      $display("FAIL target_req: req=%b addr=%h, required 1 00002000", imem_req, imem_addr);
    end
    tick();
    #2;
    vectors++;
    if (fetch_valid !== 1'b0) begin
      errors++;
      $display("FAIL dropped_not_pushed: fetch_valid=%b, required 0", fetch_valid);
    end
    tick();
    #2;
    vectors++;
    if (fetch_instr_pc !== {mem_word(32'h2000), 32'h2000}) begin
      errors++;
      $display("FAIL target_head: got %h, required %h", fetch_instr_pc, {mem_word(32'h2000), 32'h2000});
    end
    repeat (4) tick();
  endtask

  task automatic test_redirect_same_cycle();
    do_reset();
    id_ready = 1'b0;
    repeat (3) tick();
    jump = 1'b1; jaccept = 1'b1; jaddr = 32'h3000; id_ready = 1'b1;
    #2;
    vectors++;
    if (fetch_valid !== 1'b1 || imem_valid !== 1'b1) begin
      errors++;
      $display("FAIL pre_redirect_state: valid=%b imem_valid=%b, required 1 1", fetch_valid, imem_valid);
    end
    tick();
    jump = 1'b0; jaccept = 1'b0;
    #2;
    vectors++;
    if (fetch_valid !== 1'b0) begin
      errors++;
      $display("FAIL same_cycle_flush: fetch_valid=%b, required 0", fetch_valid);
    end
    vectors++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h3000) begin
      errors++;
      $display("FAIL same_cycle_target_req: req=%b addr=%h, required 1 00003000", imem_req, imem_addr);
    end
    tick();
    tick();
    #2;
    vectors++;
    if (fetch_instr_pc !== {mem_word(32'h3000), 32'h3000}) begin
      errors++;
      $display("FAIL same_cycle_head: got %h, required %h", fetch_instr_pc, {mem_word(32'h3000), 32'h3000});
    end
    repeat (4) tick();
  endtask

  task automatic test_pc_wrap();
    do_reset();
    tick();
    jump = 1'b1; jaccept = 1'b1; jaddr = 32'hFFFF_FFF8;
    tick();
    jump = 1'b0; jaccept = 1'b0;
    req_log.delete();
    repeat (6) tick();
    vectors++;
    if (req_log.size() < 3 || req_log[0] !== 32'hFFFF_FFF8 || req_log[1] !== 32'hFFFF_FFFC ||
        req_log[2] !== 32'h0000_0000) begin
      errors++;
      $display("FAIL pc_wrap: got %0d requests, first three not fffffff8/fffffffc/00000000",
               req_log.size());
    end
  endtask

  task automatic test_reset_midop();
    do_reset();
    id_ready = 1'b0;
    repeat (3) tick();
    lat_min = 3; lat_max = 3;
    tick();
    #1;
    vectors++;
    if (fetch_valid !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_valid: fetch_valid=%b, required 1", fetch_valid);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if (imem_req !== 1'b0 || fetch_valid !== 1'b0 || fetch_instr_pc !== 64'd0) begin
      errors++;
      $display("FAIL async_reset_outputs: req=%b valid=%b data=%h, required 0 0 0",
               imem_req, fetch_valid, fetch_instr_pc);
    end
    // The stale response to 0x10C lands in the first cycle after release.
    pending.delete();
    pending.push_back('{cyc + 2, 32'h10C});
    lat_min = 1; lat_max = 1;
    tick();
    tick();
    rst = 1'b0;
    id_ready = 1'b1;
    #2;
    vectors++;
    if (imem_req !== 1'b1 || imem_addr !== RESET_PC || imem_valid !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_first_req: req=%b addr=%h stale=%b, required 1 %h 1",
               imem_req, imem_addr, imem_valid, RESET_PC);
    end
    tick();
    #2;
    vectors++;
    if (fetch_valid !== 1'b0) begin
      errors++;
      $display("FAIL stale_ignored: fetch_valid=%b head=%h, required 0", fetch_valid, fetch_instr_pc);
    end
    tick();
    #2;
    vectors++;
    if (fetch_instr_pc !== {mem_word(RESET_PC), RESET_PC}) begin
      errors++;
      $display("FAIL post_reset_head: got %h, required %h", fetch_instr_pc, {mem_word(RESET_PC), RESET_PC});
    end
    repeat (4) tick();
  endtask

  task automatic test_random();
    do_reset();
    lat_min = 1; lat_max = 3;
    for (int i = 0; i < 400; i++) begin
      jump     = ($urandom_range(11, 0) == 0);
      jaccept  = ($urandom_range(3, 0) != 0);
      jaddr    = $urandom;
      id_ready = ($urandom_range(3, 0) != 0);
      tick();
    end
    jump = 1'b0; jaccept = 1'b0; id_ready = 1'b1;
    repeat (12) tick();
  endtask

  initial begin
    rst = 1'b1;
    jump = 1'b0; jaccept = 1'b0; jaddr = 32'h0; id_ready = 1'b1;
    imem_valid = 1'b0; imem_rdata = 32'h0;
    test_reset();
    test_sequential();
    test_full();
    test_redirect_drop();
    test_redirect_same_cycle();
    test_pc_wrap();
    test_reset_midop();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
